dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port, 1024x32 data memory between two requesters: port 0 is the core load/store path, port 1 is the loader/debug path.
- The memory reads combinationally and writes synchronously (write enable, address and write data are sampled at posedge).
- Each port talks to the arbiter through a valid/ready request channel and a valid/ready response channel.
- The block sits between the requesters and the memory; it owns every memory control signal.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data on every port and on the memory side.
- ADDR_BITS, 10, number of low address bits driven to the memory; upper bits pass through unchanged and are ignored by the memory.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- p0_req_valid  in  1  port 0 request present.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  DATA_WIDTH  port 0 word address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_rsp_valid  out  1  port 0 response present.
- p0_rsp_ready  in  1  port 0 consumes the response.
- p0_rdata  out  DATA_WIDTH  port 0 read data (0 for writes).
- p1_req_valid, p1_req_ready, p1_we, p1_addr, p1_wdata, p1_rsp_valid, p1_rsp_ready, p1_rdata: same as port 0, for port 1.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- FSM states:
  - IDLE -> BUSY when any req_valid is high (accept).
  - BUSY -> RESP unconditionally.
  - RESP -> IDLE when the owner's rsp_ready is high.
- Accept (IDLE only):
  - Winner chosen combinationally; only the winner's req_ready is 1, the other port's req_ready is 0.
  - req_ready is 0 in BUSY and RESP.
  - Handshake completes when req_valid and req_ready are both 1 at posedge.
  - At that edge, latch owner, we, addr and wdata into cmd registers.
- BUSY (exactly one cycle):
  - mem_addr = cmd_addr; mem_wd = cmd_wdata; mem_we = cmd_we.
  - Reads: mem_rd is captured into rdata_q at the BUSY->RESP edge.
  - Writes: rdata_q is set to 0.
- Outside BUSY: mem_we = 0, mem_addr = cmd_addr, mem_wd = cmd_wdata, so the memory address stays stable.
- RESP:
  - Owner's rsp_valid = 1 and rdata = rdata_q, both held stable until rsp_ready.
  - Non-owner rsp_valid = 0 and rdata = 0.
  - A new accept is possible the cycle after RESP exits.
- Latency: accept at edge N, memory access in cycle N+1, rsp_valid visible from N+2. Peak throughput is one transaction per 3 cycles with rsp_ready tied high.
- Simultaneous requests: port 0 wins (fixed priority) unless the optional feature is enabled. The loser keeps req_valid high and is served on its next IDLE cycle.
- Requests arriving while BUSY/RESP: not accepted (req_ready=0); requesters must hold stable until ready.
- Reset values: state=IDLE, cmd_* = 0, owner=0, rdata_q=0, all req_ready/rsp_valid = 0, mem_we=0, mem_addr=0, mem_wd=0.
- Reset mid-operation: state goes to IDLE immediately, and mem_we drops combinationally.
  - A write in BUSY is aborted if rst rises before the edge.
  - A pending response is discarded.
- Read-after-write to the same address by the other port returns the new data: the write commits at the end of BUSY, before the later read's BUSY cycle.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a last_grant register, updated on every accept; reset value 1, so port 0 wins the first tie.
  - On a tie the port not in last_grant wins.
  - A single requester always wins regardless of last_grant.
- Undefined: fixed priority, port 0 always wins ties; no last_grant register is built.

Test Plan:
- Reset then p0 write addr=0x05 data=0xDEADBEEF, rsp_ready=1 -> p0_req_ready=1 on the same cycle; mem_we=1 for exactly one cycle with mem_addr=0x05; p0_rsp_valid at N+2 with p0_rdata=0.
- p1 read addr=0x05 after the write above -> p1_rsp_valid with p1_rdata=0xDEADBEEF at N+2; p0_rsp_valid stays 0.
- Both ports request every cycle, rsp_ready=1, fixed priority -> port 0 served every transaction, p1_req_ready never 1. With DMEM_ARB_RR_EN -> grants alternate 0,1,0,1 with 3 cycles per grant.
- p0 read with p0_rsp_ready=0 for 5 cycles -> p0_rsp_valid and p0_rdata held stable 5 cycles, no new accept, mem_we=0 throughout; IDLE the cycle after rsp_ready=1.
- rst asserted asynchronously mid-BUSY of a p1 write to addr=0x3FF -> mem_we drops immediately, memory word 0x3FF unchanged, all outputs at reset values.
- p0 addr=0x0000_0405 write 0x1 -> mem_addr carries the full value; the memory decodes word 0x005 via address bits [9:0], and a read of 0x005 returns 0x1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter in front of a single-port 1024x32 data memory.
// Optional round-robin tie-break is built when DMEM_ARB_RR_EN is defined; fixed port-0 priority otherwise.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p0_req_valid_i,
    output logic                  p0_req_ready_o,
    input  logic                  p0_we_i,
    input  logic [DATA_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic                  p0_rsp_valid_o,
    input  logic                  p0_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    input  logic                  p1_req_valid_i,
    output logic                  p1_req_ready_o,
    input  logic                  p1_we_i,
    input  logic [DATA_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    output logic                  p1_rsp_valid_o,
    input  logic                  p1_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [DATA_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            grant_s;
    logic                  owner_rsp_ready_s;

`ifdef DMEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;
`endif

    // Winner selection: only in IDLE, at most one grant bit set.
    always_comb begin
        grant_s = 2'b00;
        if ((state_q == ST_IDLE) && !rst_i) begin
`ifdef DMEM_ARB_RR_EN
            if (p0_req_valid_i && p1_req_valid_i) begin
                grant_s = last_grant_q ? 2'b01 : 2'b10;
            end
`else
            if (p0_req_valid_i && p1_req_valid_i) begin
                grant_s = 2'b01;
            end
`endif
            else if (p0_req_valid_i) begin
                grant_s = 2'b01;
            end else if (p1_req_valid_i) begin
                grant_s = 2'b10;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember which port won the most recent accept.
    always_comb begin
        if (grant_s != 2'b00) begin
            last_grant_d = grant_s[1];
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin history register; 1 after reset so port 0 takes the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign owner_rsp_ready_s = owner_q ? p1_rsp_ready_i : p0_rsp_ready_i;

    // Next-state and command/response register updates.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    state_d     = ST_BUSY;
                    owner_d     = grant_s[1];
                    cmd_we_d    = grant_s[1] ? p1_we_i    : p0_we_i;
                    cmd_addr_d  = grant_s[1] ? p1_addr_i  : p0_addr_i;
                    cmd_wdata_d = grant_s[1] ? p1_wdata_i : p0_wdata_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                state_d = ST_RESP;
                rdata_d = cmd_we_q ? {DATA_WIDTH{1'b0}} : mem_rd_i;
            end
            ST_RESP: begin
                if (owner_rsp_ready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and command registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= {DATA_WIDTH{1'b0}};
            cmd_wdata_q <= {DATA_WIDTH{1'b0}};
            rdata_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign p0_req_ready_o = grant_s[0];
    assign p1_req_ready_o = grant_s[1];

    // The write strobe is also masked by reset so a write caught mid-BUSY never commits.
    assign mem_we_o   = (state_q == ST_BUSY) && cmd_we_q && !rst_i;
    // Memory decodes only the low ADDR_BITS; the upper field is carried through untouched.
    assign mem_addr_o = {cmd_addr_q[DATA_WIDTH-1:ADDR_BITS], cmd_addr_q[ADDR_BITS-1:0]};
    assign mem_wd_o   = cmd_wdata_q;

    assign p0_rsp_valid_o = (state_q == ST_RESP) && !owner_q;
    assign p1_rsp_valid_o = (state_q == ST_RESP) &&  owner_q;
    assign p0_rdata_o     = p0_rsp_valid_o ? rdata_q : {DATA_WIDTH{1'b0}};
    assign p1_rdata_o     = p1_rsp_valid_o ? rdata_q : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (accept order defines memory order, response due two cycles after accept).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, we, rsp_valid, rsp_ready;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_init;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .p0_req_valid_i(req_valid[0]), .p0_req_ready_o(req_ready[0]), .p0_we_i(we[0]),
        .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]), .p0_rsp_valid_o(rsp_valid[0]),
        .p0_rsp_ready_i(rsp_ready[0]), .p0_rdata_o(rdata[0]),
        .p1_req_valid_i(req_valid[1]), .p1_req_ready_o(req_ready[1]), .p1_we_i(we[1]),
        .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]), .p1_rsp_valid_o(rsp_valid[1]),
        .p1_rsp_ready_i(rsp_ready[1]), .p1_rdata_o(rdata[1]),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    // Behavioural memory: combinational read, synchronous write, word index from bits [9:0].
    assign mem_rd = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wd;
        end
    end

    task automatic idle_inputs();
        req_valid = 2'b00; we = 2'b00; rsp_ready = 2'b11;
        for (int p = 0; p < 2; p++) begin addr[p] = 32'h0; wdata[p] = 32'h0; end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; mem_init = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_bus addr=%h wd=%h exp=0", mem_addr, mem_wd); end
        checks++; if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata[0], rdata[1]); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00 || mem_we !== 1'b0) begin errors++; $display("FAIL post_reset_idle rsp=%b we=%b", rsp_valid, mem_we); end
    endtask

    // Single transaction with rsp_ready high; checks accept, BUSY, RESP and return to IDLE.
    task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input string tag);
        logic [1:0] onehot;
        onehot = (p == 0) ? 2'b01 : 2'b10;
        req_valid[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; rsp_ready = 2'b11;
        #1;
        checks++; if (req_ready !== onehot) begin errors++; $display("FAIL %s_accept ready=%b exp=%b", tag, req_ready, onehot); end
        @(negedge clk);
        req_valid[p] = 1'b0;
        checks++; if (mem_we !== w) begin errors++; $display("FAIL %s_busy_we got=%b exp=%b", tag, mem_we, w); end
        checks++; if (mem_addr !== a || mem_wd !== d) begin errors++; $display("FAIL %s_busy_bus addr=%h wd=%h exp=%h/%h", tag, mem_addr, mem_wd, a, d); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL %s_busy_ready got=%b exp=00", tag, req_ready); end
        @(negedge clk);
        checks++; if (rsp_valid !== onehot) begin errors++; $display("FAIL %s_rsp_valid got=%b exp=%b", tag, rsp_valid, onehot); end
        checks++; if (rdata[p] !== exp_rd || rdata[1-p] !== 32'h0) begin errors++; $display("FAIL %s_rdata got=%h other=%h exp=%h", tag, rdata[p], rdata[1-p], exp_rd); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s_resp_we got=%b exp=0", tag, mem_we); end
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL %s_idle_rsp got=%b exp=00", tag, rsp_valid); end
    endtask

    task automatic test_write_read();
        do_txn(0, 1'b1, 32'h5, 32'hDEADBEEF, 32'h0, "p0_write");
        ref_mem[5] = 32'hDEADBEEF;
        do_txn(1, 1'b0, 32'h5, 32'h0, 32'hDEADBEEF, "p1_raw_read");
    endtask

    task automatic test_backpressure();
        req_valid = 2'b11; we = 2'b00; addr[0] = 32'h5; addr[1] = 32'h200; rsp_ready = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept ready=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 2'b01 || rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h exp=01/deadbeef", i, rsp_valid, rdata[0]); end
            checks++; if (req_ready !== 2'b00 || mem_we !== 1'b0) begin errors++; $display("FAIL bp_quiet cyc=%0d ready=%b we=%b exp=00/0", i, req_ready, mem_we); end
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin errors++; $display("FAIL bp_release rsp=%b ready=%b exp=00/10", rsp_valid, req_ready); end
        req_valid[1] = 1'b0;
        do_txn(1, 1'b0, 32'h200, 32'h0, 32'h0, "bp_p1_read");
    endtask

    task automatic test_contention();
        int n_grant, last_cyc, exp_w, w;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req_valid = 2'b11; we = 2'b00; addr[0] = 32'h200; addr[1] = 32'h201; rsp_ready = 2'b11;
        n_grant = 0; last_cyc = -1; exp_w = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready !== 2'b00) begin
                w = (req_ready == 2'b10) ? 1 : 0;
                checks++; if (req_ready !== 2'b01 && req_ready !== 2'b10) begin errors++; $display("FAIL cont_onehot ready=%b", req_ready); end
                checks++; if (w != exp_w) begin errors++; $display("FAIL cont_winner grant=%0d got=%0d exp=%0d", n_grant, w, exp_w); end
                if (last_cyc >= 0) begin
                    checks++; if (c - last_cyc != 3) begin errors++; $display("FAIL cont_spacing got=%0d exp=3", c - last_cyc); end
                end
                last_cyc = c; n_grant++;
`ifdef DMEM_ARB_RR_EN
                exp_w = 1 - w;
`endif
            end
            if (c == 11) req_valid = 2'b00;
            @(negedge clk);
        end
        checks++; if (n_grant != 4) begin errors++; $display("FAIL cont_count got=%0d exp=4", n_grant); end
    endtask

    task automatic test_reset_mid_busy();
        req_valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h3FF; wdata[1] = 32'h12345678;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rmb_accept ready=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h3FF) begin errors++; $display("FAIL rmb_busy we=%b addr=%h exp=1/3ff", mem_we, mem_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmb_we_drop got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL rmb_outputs addr=%h wd=%h ready=%b rsp=%b", mem_addr, mem_wd, req_ready, rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem[1023] !== 32'h0) begin errors++; $display("FAIL rmb_mem_unchanged got=%h exp=0", mem[1023]); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rmb_rsp_discard got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_addr_alias();
        do_txn(0, 1'b1, 32'h0000_0405, 32'h1, 32'h0, "alias_write");
        ref_mem[5] = 32'h1;
        checks++; if (mem[5] !== 32'h1) begin errors++; $display("FAIL alias_mem_word got=%h exp=1", mem[5]); end
        do_txn(0, 1'b0, 32'h0000_0005, 32'h0, 32'h1, "alias_read");
    endtask

    task automatic test_random();
        logic [1:0]  just_acc;
        logic        outstanding, cur_we, last_rr;
        int          own, acc_cyc, winner, txns;
        logic [31:0] exp_rd, cur_addr;
        logic [1:0]  exp_ready, exp_rv;
        rst = 1'b1; idle_inputs(); @(negedge clk); rst = 1'b0;
        just_acc = 2'b00; outstanding = 1'b0; last_rr = 1'b1; txns = 0;
        own = 0; acc_cyc = 0; cur_we = 1'b0; cur_addr = 32'h0; exp_rd = 32'h0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (just_acc[p] || !req_valid[p]) begin
                    req_valid[p] = (cyc < 780) ? 1'($urandom_range(0, 1)) : 1'b0;
                    we[p]    = 1'($urandom_range(0, 1));
                    addr[p]  = {22'($urandom_range(0, 3)), 10'(10'h100 + 10'($urandom_range(0, 7)))};
                    wdata[p] = $urandom;
                end
            end
            just_acc = 2'b00;
            rsp_ready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            #1;
            checks++; if (req_ready === 2'b11) begin errors++; $display("FAIL rnd_double_ready cyc=%0d", cyc); end
            winner = 0;
            if (!outstanding && req_valid != 2'b00) begin
                if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
                    winner = last_rr ? 0 : 1;
`else
                    winner = 0;
`endif
                end else begin
                    winner = req_valid[1] ? 1 : 0;
                end
                exp_ready = (winner == 0) ? 2'b01 : 2'b10;
                checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            end else begin
                checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rnd_busy_ready cyc=%0d got=%b exp=00", cyc, req_ready); end
            end
            checks++; if (mem_we !== (outstanding && cyc == acc_cyc + 1 && cur_we)) begin errors++; $display("FAIL rnd_mem_we cyc=%0d got=%b", cyc, mem_we); end
            if (outstanding && cyc == acc_cyc + 1) begin
                checks++; if (mem_addr !== cur_addr) begin errors++; $display("FAIL rnd_mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, cur_addr); end
            end
            exp_rv = (outstanding && cyc >= acc_cyc + 2) ? ((own == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
            if (exp_rv != 2'b00) begin
                checks++; if (rdata[own] !== exp_rd || rdata[1-own] !== 32'h0) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h other=%h exp=%h", cyc, rdata[own], rdata[1-own], exp_rd); end
            end
            if (exp_rv != 2'b00 && rsp_ready[own]) begin
                outstanding = 1'b0;
            end else if (!outstanding && req_valid != 2'b00) begin
                own = winner; acc_cyc = cyc; outstanding = 1'b1; last_rr = 1'(winner);
                cur_we = we[winner]; cur_addr = addr[winner];
                if (cur_we) begin
                    ref_mem[cur_addr[9:0]] = wdata[winner]; exp_rd = 32'h0;
                end else begin
                    exp_rd = ref_mem[cur_addr[9:0]];
                end
                just_acc[winner] = 1'b1; txns++;
            end
        end
        checks++; if (outstanding) begin errors++; $display("FAIL rnd_drain transaction still open"); end
        checks++; if (txns < 50) begin errors++; $display("FAIL rnd_progress got=%0d exp>=50", txns); end
    endtask

    initial begin
        mem_init = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_contention();
        test_reset_mid_busy();
        test_addr_alias();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
